// File: rtl/demux_32to64.sv
`default_nettype none
// ============================================================================
//  Module      : demux_32to64
//  Description : Registered 1-to-2 word demultiplexer. One input stream with
//                a per-word select bit is split into two independent output
//                channels (A for in_sel=0, B for in_sel=1). Each channel owns
//                a one-entry holding register and a valid/ready handshake, so
//                a stalled sink never blocks the other channel. Per-channel
//                wrapping transfer counters count delivered words.
//
//  Ports:
//    clk, rst_n               clock, asynchronous active-low reset
//    in_data/in_sel/in_valid  upstream word, destination select, valid
//    in_ready                 block accepts the presented word this cycle
//    a_data/a_valid/a_ready   channel A output handshake
//    b_data/b_valid/b_ready   channel B output handshake
//    a_cnt/b_cnt              words delivered on A / B (wrap, no flag)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_32to64 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,

    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,

    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,

    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    chan_state_t r_a_state;
    chan_state_t r_b_state;
    chan_state_t w_a_state_nxt;
    chan_state_t w_b_state_nxt;

    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic [CNT_W-1:0] r_a_cnt;
    logic [CNT_W-1:0] r_b_cnt;

    logic w_a_room;
    logic w_b_room;
    logic w_in_xfer;
    logic w_load_a;
    logic w_load_b;
    logic w_a_hs;
    logic w_b_hs;

    // ------------------------------------------------------------------------
    // Input side. A channel can take a new word when it is empty, or when its
    // current word leaves this same cycle (pass-through without a bubble).
    // in_ready depends only on in_sel, channel state and the selected sink's
    // ready; in_valid and in_data are deliberately kept out of this path.
    // ------------------------------------------------------------------------
    assign w_a_room  = (r_a_state == ST_EMPTY) || a_ready;
    assign w_b_room  = (r_b_state == ST_EMPTY) || b_ready;
    assign in_ready  = in_sel ? w_b_room : w_a_room;

    assign w_in_xfer = in_valid && in_ready;
    // Only the selected channel is ever loaded.
    assign w_load_a  = w_in_xfer && !in_sel;
    assign w_load_b  = w_in_xfer &&  in_sel;

    // Output handshakes.
    assign w_a_hs    = (r_a_state == ST_FULL) && a_ready;
    assign w_b_hs    = (r_b_state == ST_FULL) && b_ready;

    // ------------------------------------------------------------------------
    // Channel A state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_state_nxt = r_a_state;
        case (r_a_state)
            ST_EMPTY: begin
                if (w_load_a) begin
                    w_a_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // Drain with a simultaneous reload stays FULL.
                if (w_a_hs && !w_load_a) begin
                    w_a_state_nxt = ST_EMPTY;
                end
            end
            default: w_a_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_state <= ST_EMPTY;
        end else begin
            r_a_state <= w_a_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Channel B state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_b_state_nxt = r_b_state;
        case (r_b_state)
            ST_EMPTY: begin
                if (w_load_b) begin
                    w_b_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_b_hs && !w_load_b) begin
                    w_b_state_nxt = ST_EMPTY;
                end
            end
            default: w_b_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_state <= ST_EMPTY;
        end else begin
            r_b_state <= w_b_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Holding registers: change only on a load, so data stays stable while a
    // FULL channel waits for its sink.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_data <= '0;
        end else if (w_load_a) begin
            r_a_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_data <= '0;
        end else if (w_load_b) begin
            r_b_data <= in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Delivered-word counters; natural binary wrap at 2^CNT_W.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_cnt <= '0;
        end else if (w_a_hs) begin
            r_a_cnt <= r_a_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_cnt <= '0;
        end else if (w_b_hs) begin
            r_b_cnt <= r_b_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign a_valid = (r_a_state == ST_FULL);
    assign b_valid = (r_b_state == ST_FULL);
    assign a_data  = r_a_data;
    assign b_data  = r_b_data;
    assign a_cnt   = r_a_cnt;
    assign b_cnt   = r_b_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_32to64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_32to64
//  Description : Directed self-checking bench for demux_32to64. Inputs are
//                driven and outputs observed 1 ns after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_32to64;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;

    int n_cmp;
    int n_fail;

    demux_32to64 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        step();
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_data  = 32'h0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        #2;
        n_cmp++; if ({a_valid, b_valid} !== 2'b00) begin $display("FAIL reset_valid: got %b expected 00", {a_valid, b_valid}); n_fail++; end
        n_cmp++; if ({a_data, b_data} !== 64'h0) begin $display("FAIL reset_data: got %h expected 0", {a_data, b_data}); n_fail++; end
        n_cmp++; if ({a_cnt, b_cnt} !== 32'h0) begin $display("FAIL reset_cnt: got %h expected 0", {a_cnt, b_cnt}); n_fail++; end
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready_sel0: got %b expected 1", in_ready); n_fail++; end
        in_sel = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready_sel1: got %b expected 1", in_ready); n_fail++; end
        step();
        #2;
        rst_n = 1'b1;
        step();
        // Load A with a word that the sink will not take, then reset mid-cycle.
        in_sel   = 1'b0;
        in_data  = 32'h12345678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (a_valid !== 1'b1 || a_data !== 32'h12345678) begin $display("FAIL reset_preload_a: got v=%b d=%h expected v=1 d=12345678", a_valid, a_data); n_fail++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_valid !== 1'b0) begin $display("FAIL reset_async_a_valid: got %b expected 0", a_valid); n_fail++; end
        n_cmp++; if (a_cnt !== 16'd0) begin $display("FAIL reset_async_a_cnt: got %0d expected 0", a_cnt); n_fail++; end
        a_ready = 1'b1;
        step();
        #2;
        rst_n = 1'b1;
        step();
        n_cmp++; if (a_cnt !== 16'd0 || a_valid !== 1'b0) begin $display("FAIL reset_discard: got cnt=%0d v=%b expected cnt=0 v=0", a_cnt, a_valid); n_fail++; end
    endtask

    task automatic test_stream_a();
        in_sel  = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_data  = i;
            in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); n_fail++; end
            step();
            n_cmp++; if (a_valid !== 1'b1 || a_data !== i) begin $display("FAIL stream_a[%0d]: got v=%b d=%h expected v=1 d=%h", i, a_valid, a_data, i); n_fail++; end
            n_cmp++; if (b_valid !== 1'b0) begin $display("FAIL stream_b_idle[%0d]: got %b expected 0", i, b_valid); n_fail++; end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (a_valid !== 1'b0 || a_cnt !== 16'd8) begin $display("FAIL stream_done: got v=%b cnt=%0d expected v=0 cnt=8", a_valid, a_cnt); n_fail++; end
    endtask

    task automatic test_alternate();
        logic [31:0] w;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w        = 32'hA0000000 + i;
            in_data  = w;
            in_sel   = i[0];
            in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL alt_in_ready[%0d]: got %b expected 1", i, in_ready); n_fail++; end
            step();
            if (i[0] == 1'b0) begin
                n_cmp++; if (a_valid !== 1'b1 || a_data !== w) begin $display("FAIL alt_a[%0d]: got v=%b d=%h expected v=1 d=%h", i, a_valid, a_data, w); n_fail++; end
            end else begin
                n_cmp++; if (b_valid !== 1'b1 || b_data !== w) begin $display("FAIL alt_b[%0d]: got v=%b d=%h expected v=1 d=%h", i, b_valid, b_data, w); n_fail++; end
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (a_cnt !== 16'd12 || b_cnt !== 16'd4) begin $display("FAIL alt_cnt: got a=%0d b=%0d expected a=12 b=4", a_cnt, b_cnt); n_fail++; end
    endtask

    task automatic test_stall_b();
        a_ready  = 1'b1;
        b_ready  = 1'b0;
        in_sel   = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        step();
        n_cmp++; if (b_valid !== 1'b1 || b_data !== 32'hDEADBEEF) begin $display("FAIL stall_b_load: got v=%b d=%h expected v=1 d=deadbeef", b_valid, b_data); n_fail++; end
        in_data = 32'hCAFEF00D;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL stall_in_ready_b: got %b expected 0", in_ready); n_fail++; end
        step();
        n_cmp++; if (b_data !== 32'hDEADBEEF || b_cnt !== 16'd4) begin $display("FAIL stall_b_hold: got d=%h cnt=%0d expected d=deadbeef cnt=4", b_data, b_cnt); n_fail++; end
        // A is still open while B is stalled.
        in_sel  = 1'b0;
        in_data = 32'h5555AAAA;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL stall_in_ready_a: got %b expected 1", in_ready); n_fail++; end
        step();
        n_cmp++; if (a_valid !== 1'b1 || a_data !== 32'h5555AAAA) begin $display("FAIL stall_a_pass: got v=%b d=%h expected v=1 d=5555aaaa", a_valid, a_data); n_fail++; end
        in_sel  = 1'b1;
        in_data = 32'hCAFEF00D;
        b_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || b_data !== 32'hDEADBEEF) begin $display("FAIL stall_release: got rdy=%b d=%h expected rdy=1 d=deadbeef", in_ready, b_data); n_fail++; end
        step();
        in_valid = 1'b0;
        n_cmp++; if (b_valid !== 1'b1 || b_data !== 32'hCAFEF00D || b_cnt !== 16'd5) begin $display("FAIL stall_pending_b: got v=%b d=%h cnt=%0d expected v=1 d=cafef00d cnt=5", b_valid, b_data, b_cnt); n_fail++; end
        step();
        n_cmp++; if (b_valid !== 1'b0 || b_cnt !== 16'd6 || a_cnt !== 16'd13) begin $display("FAIL stall_drain: got v=%b b=%0d a=%0d expected v=0 b=6 a=13", b_valid, b_cnt, a_cnt); n_fail++; end
    endtask

    task automatic test_back_to_back();
        a_ready  = 1'b0;
        in_sel   = 1'b0;
        in_data  = 32'h11111111;
        in_valid = 1'b1;
        step();
        n_cmp++; if (a_valid !== 1'b1 || a_data !== 32'h11111111) begin $display("FAIL b2b_first: got v=%b d=%h expected v=1 d=11111111", a_valid, a_data); n_fail++; end
        a_ready = 1'b1;
        in_data = 32'h22222222;
        step();
        in_valid = 1'b0;
        n_cmp++; if (a_valid !== 1'b1 || a_data !== 32'h22222222 || a_cnt !== 16'd14) begin $display("FAIL b2b_reload: got v=%b d=%h cnt=%0d expected v=1 d=22222222 cnt=14", a_valid, a_data, a_cnt); n_fail++; end
        step();
        n_cmp++; if (a_valid !== 1'b0 || a_cnt !== 16'd15) begin $display("FAIL b2b_drain: got v=%b cnt=%0d expected v=0 cnt=15", a_valid, a_cnt); n_fail++; end
    endtask

    task automatic test_wrap();
        apply_reset();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = i;
            step();
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (b_cnt !== 16'hFFFF || a_cnt !== 16'd0) begin $display("FAIL wrap_pre: got b=%h a=%h expected b=ffff a=0000", b_cnt, a_cnt); n_fail++; end
        in_data  = 32'h0BADF00D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (b_valid !== 1'b1 || b_data !== 32'h0BADF00D) begin $display("FAIL wrap_word: got v=%b d=%h expected v=1 d=0badf00d", b_valid, b_data); n_fail++; end
        step();
        n_cmp++; if (b_cnt !== 16'h0000 || a_cnt !== 16'd0) begin $display("FAIL wrap_cnt: got b=%h a=%h expected b=0000 a=0000", b_cnt, a_cnt); n_fail++; end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_stream_a();
        test_alternate();
        test_stall_b();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
